laconic_term_packer: RTL and testbench

Producer side of the Laconic PE lane interface. Accepts a stream of signed 8-bit activation/weight operand pairs, encodes each operand into canonical-signed-digit (CSD) power-of-two terms, and forms every activation-term x weight-term pair. It packs those term pairs densely into 16-lane bundles (`in_applied`, `t0`, `t1`, `s0`, `s1`) that feed the PE core's compact-GPC adder tree, with valid/ready handshakes on both sides.

---
 rtl/laconic_pkg.sv | 27 ++
 rtl/laconic_csd_enc.sv | 36 +++
 rtl/laconic_term_packer.sv | 196 +++++++++++++++++++
 tb/tb_laconic_term_packer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/laconic_pkg.sv
// Shared constants, term/lane types and FSM state encoding for the Laconic term packer.
package laconic_pkg;

    localparam int unsigned LANES     = 16;
    localparam int unsigned EXP_W     = 3;
    localparam int unsigned OP_W      = 8;
    localparam int unsigned MAX_TERMS = 4;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic             neg;
    } term_t;

    typedef struct packed {
        logic             applied;
        logic [EXP_W-1:0] t0;
        logic [EXP_W-1:0] t1;
        logic             s0;
        logic             s1;
    } lane_t;

    typedef enum logic {
        ST_FILL,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/laconic_csd_enc.sv
// Combinational 8-bit two's-complement to canonical-signed-digit (NAF) encoder,
// emitting up to four power-of-two terms ordered by descending exponent.
module laconic_csd_enc
    import laconic_pkg::*;
(
    input  logic [OP_W-1:0]             op_i,
    output term_t [MAX_TERMS-1:0]       terms_o,
    output logic [2:0]                  cnt_o
);

    logic [OP_W-1:0] half;
    logic [OP_W-1:0] sum;
    logic [OP_W-1:0] pos;
    logic [OP_W-1:0] neg;

    // NAF digit i is bit i of floor(3x/2) minus bit i of floor(x/2).
    always_comb begin
        half = {op_i[OP_W-1], op_i[OP_W-1:1]};
        sum  = op_i + half;
        pos  = sum & ~half;
        neg  = half & ~sum;
    end

    always_comb begin
        terms_o = '0;
        cnt_o   = '0;
        for (int unsigned j = 0; j < OP_W; j++) begin
            if ((pos[OP_W-1-j] | neg[OP_W-1-j]) && (cnt_o < 3'(MAX_TERMS))) begin
                terms_o[cnt_o[1:0]].exp = 3'(OP_W-1-j);
                terms_o[cnt_o[1:0]].neg = neg[OP_W-1-j];
                cnt_o = cnt_o + 3'd1;
            end
        end
    end

endmodule

// File: rtl/laconic_term_packer.sv
// Packs CSD activation x weight term pairs into 16-lane bundles for the PE core.
// Optional LACONIC_TERM_STATS_EN adds stat_terms / stat_bundles counters.
module laconic_term_packer
    import laconic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       in_act,
    input  logic [OP_W-1:0]       in_wgt,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      in_applied,
    output logic [LANES*EXP_W-1:0] t0,
    output logic [LANES*EXP_W-1:0] t1,
    output logic [LANES-1:0]      s0,
    output logic [LANES-1:0]      s1,
`ifdef LACONIC_TERM_STATS_EN
    output logic [31:0]           stat_terms,
    output logic [31:0]           stat_bundles,
`endif
    output logic                  out_last
);

    state_t                 state_q, state_d;
    lane_t [LANES-1:0]      buf_q, buf_d;
    lane_t [LANES-1:0]      spill_q, spill_d;
    logic [3:0]             f_q, f_d;
    logic [3:0]             spill_cnt_q, spill_cnt_d;
    logic                   last_pend_q, last_pend_d;
    logic                   out_last_q, out_last_d;

    term_t [MAX_TERMS-1:0]  a_terms, w_terms;
    logic [2:0]             a_cnt, w_cnt;
    lane_t [LANES-1:0]      prod;
    logic [4:0]             n;
    logic [4:0]             sum;
    logic [4:0]             pos5;
    lane_t [LANES-1:0]      merged;
    lane_t [LANES-1:0]      spill;

    laconic_csd_enc u_enc_act (.op_i(in_act), .terms_o(a_terms), .cnt_o(a_cnt));
    laconic_csd_enc u_enc_wgt (.op_i(in_wgt), .terms_o(w_terms), .cnt_o(w_cnt));

    always_comb begin
        prod = '0;
        n    = '0;
        for (int unsigned a = 0; a < MAX_TERMS; a++) begin
            for (int unsigned w = 0; w < MAX_TERMS; w++) begin
                if ((3'(a) < a_cnt) && (3'(w) < w_cnt)) begin
                    prod[n[3:0]] = '{applied: 1'b1,
                                     t0: a_terms[a].exp, t1: w_terms[w].exp,
                                     s0: a_terms[a].neg, s1: w_terms[w].neg};
                    n = n + 5'd1;
                end
            end
        end
    end

    // Product k lands at fill position f+k; positions 16.. wrap into the spill bank.
    always_comb begin
        merged = buf_q;
        spill  = '0;
        pos5   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (5'(k) < n) begin
                pos5 = {1'b0, f_q} + 5'(k);
                if (pos5 < 5'd16) merged[4'd15 - pos5[3:0]] = prod[k];
                else              spill[4'd15 - pos5[3:0]]  = prod[k];
            end
        end
    end

    assign sum = {1'b0, f_q} + n;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        f_d         = f_q;
        spill_d     = spill_q;
        spill_cnt_d = spill_cnt_q;
        last_pend_d = last_pend_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    buf_d = merged;
                    if (sum < 5'd16) begin
                        if (in_last) begin
                            state_d    = ST_EMIT;
                            out_last_d = 1'b1;
                        end else begin
                            f_d = sum[3:0];
                        end
                    end else begin
                        state_d    = ST_EMIT;
                        out_last_d = (sum == 5'd16) ? in_last : 1'b0;
                        if (sum > 5'd16) begin
                            spill_d     = spill;
                            spill_cnt_d = sum[3:0];
                            last_pend_d = in_last;
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (spill_cnt_q != 4'd0) begin
                        buf_d       = spill_q;
                        f_d         = spill_cnt_q;
                        spill_d     = '0;
                        spill_cnt_d = '0;
                        last_pend_d = 1'b0;
                        if (last_pend_q) begin
                            out_last_d = 1'b1;
                        end else begin
                            state_d    = ST_FILL;
                            out_last_d = 1'b0;
                        end
                    end else begin
                        buf_d      = '0;
                        f_d        = '0;
                        state_d    = ST_FILL;
                        out_last_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            buf_q       <= '0;
            f_q         <= '0;
            spill_q     <= '0;
            spill_cnt_q <= '0;
            last_pend_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            f_q         <= f_d;
            spill_q     <= spill_d;
            spill_cnt_q <= spill_cnt_d;
            last_pend_q <= last_pend_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = out_last_q;

    always_comb begin
        in_applied = '0;
        t0         = '0;
        t1         = '0;
        s0         = '0;
        s1         = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            in_applied[k]          = buf_q[k].applied;
            t0[EXP_W*k +: EXP_W]   = buf_q[k].t0;
            t1[EXP_W*k +: EXP_W]   = buf_q[k].t1;
            s0[k]                  = buf_q[k].s0;
            s1[k]                  = buf_q[k].s1;
        end
    end

`ifdef LACONIC_TERM_STATS_EN
    logic [31:0] stat_terms_q, stat_bundles_q;
    logic [4:0]  pop;

    always_comb begin
        pop = '0;
        for (int unsigned k = 0; k < LANES; k++) pop = pop + 5'(in_applied[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_terms_q   <= '0;
            stat_bundles_q <= '0;
        end else if (out_valid && out_ready) begin
            stat_terms_q   <= stat_terms_q + 32'(pop);
            stat_bundles_q <= stat_bundles_q + 32'd1;
        end
    end

    assign stat_terms   = stat_terms_q;
    assign stat_bundles = stat_bundles_q;
`endif

endmodule

// File: tb/tb_laconic_term_packer.sv
// Directed self-checking bench for laconic_term_packer (hand-computed bundles).
module tb_laconic_term_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_act;
    logic [7:0]  in_wgt;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] in_applied;
    logic [47:0] t0;
    logic [47:0] t1;
    logic [15:0] s0;
    logic [15:0] s1;
    logic        out_last;
`ifdef LACONIC_TERM_STATS_EN
    logic [31:0] stat_terms;
    logic [31:0] stat_bundles;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    laconic_term_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_wgt     (in_wgt),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .in_applied (in_applied),
        .t0         (t0),
        .t1         (t1),
        .s0         (s0),
        .s1         (s1),
`ifdef LACONIC_TERM_STATS_EN
        .stat_terms   (stat_terms),
        .stat_bundles (stat_bundles),
`endif
        .out_last   (out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] w, input logic l);
        int unsigned waited = 0;
        in_act   = a;
        in_wgt   = w;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        check("send_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_act    = '0;
        in_wgt    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_applied", 64'(in_applied), 64'd0);
        check("rst_t0", 64'(t0), 64'd0);

        // 30 x 7, last
        send(8'd30, 8'd7, 1'b1);
        check("s1_out_valid", 64'(out_valid), 64'd1);
        check("s1_in_ready", 64'(in_ready), 64'd0);
        check("s1_applied", 64'(in_applied), 64'h0000_F000);
        check("s1_t0", 64'(t0), 64'hB490_0000_0000);
        check("s1_t1", 64'(t1), 64'h6180_0000_0000);
        check("s1_s0", 64'(s0), 64'h3000);
        check("s1_s1", 64'(s1), 64'h5000);
        check("s1_last", 64'(out_last), 64'd1);
        take();
        check("s1_post_valid", 64'(out_valid), 64'd0);

        // 85 x -85, full bundle
        send(8'd85, 8'hAB, 1'b1);
        check("s2_applied", 64'(in_applied), 64'hFFFF);
        check("s2_t0", 64'(t0), 64'hDB69_2449_2000);
        check("s2_t1", 64'(t1), 64'hD10D_10D1_0D10);
        check("s2_s0", 64'(s0), 64'h0000);
        check("s2_s1", 64'(s1), 64'hFFFF);
        check("s2_last", 64'(out_last), 64'd1);
        take();

        // 3 x 1 then 85 x 85 with spill and last
        send(8'd3, 8'd1, 1'b0);
        check("s3_fill_ready", 64'(in_ready), 64'd1);
        check("s3_fill_valid", 64'(out_valid), 64'd0);
        send(8'd85, 8'd85, 1'b1);
        check("s3a_valid", 64'(out_valid), 64'd1);
        check("s3a_applied", 64'(in_applied), 64'hFFFF);
        check("s3a_t0", 64'(t0), 64'h436D_A491_2480);
        check("s3a_t1", 64'(t1), 64'h0344_3443_4434);
        check("s3a_s0", 64'(s0), 64'h4000);
        check("s3a_s1", 64'(s1), 64'h0000);
        check("s3a_last", 64'(out_last), 64'd0);
        take();
        check("s3b_valid", 64'(out_valid), 64'd1);
        check("s3b_in_ready", 64'(in_ready), 64'd0);
        check("s3b_applied", 64'(in_applied), 64'hC000);
        check("s3b_t0", 64'(t0), 64'h0);
        check("s3b_t1", 64'(t1), 64'h4000_0000_0000);
        check("s3b_last", 64'(out_last), 64'd1);
        take();
        check("s3_done_valid", 64'(out_valid), 64'd0);
`ifdef LACONIC_TERM_STATS_EN
        check("stat_terms", 64'(stat_terms), 64'd38);
        check("stat_bundles", 64'(stat_bundles), 64'd4);
`endif

        // zero activation: empty bundle with last
        send(8'd0, 8'd55, 1'b1);
        check("s4_valid", 64'(out_valid), 64'd1);
        check("s4_applied", 64'(in_applied), 64'd0);
        check("s4_last", 64'(out_last), 64'd1);
        take();

        // -128 x -128: single term each, both negative at exponent 7
        send(8'h80, 8'h80, 1'b1);
        check("neg_applied", 64'(in_applied), 64'h8000);
        check("neg_t0", 64'(t0), 64'hE000_0000_0000);
        check("neg_t1", 64'(t1), 64'hE000_0000_0000);
        check("neg_s0", 64'(s0), 64'h8000);
        check("neg_s1", 64'(s1), 64'h8000);
        take();

        // backpressure hold, then reset
        send(8'd30, 8'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_applied", 64'(in_applied), 64'h0000_F000);
            check("hold_t0", 64'(t0), 64'hB490_0000_0000);
        end
        pulse_rst();
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_applied", 64'(in_applied), 64'd0);
        check("rst2_last", 64'(out_last), 64'd0);

        // partial fill discarded by reset
        send(8'd3, 8'd1, 1'b0);
        pulse_rst();
        send(8'd1, 8'd1, 1'b1);
        check("fresh_applied", 64'(in_applied), 64'h8000);
        check("fresh_t0", 64'(t0), 64'd0);
        check("fresh_s0", 64'(s0), 64'd0);
        check("fresh_last", 64'(out_last), 64'd1);
        take();
        check("end_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
